// File: rtl/prm_router_if.sv
// Decode-to-consumer parameter bus: instruction-side strobe/fields in, per-channel values out.
interface prm_router_if #(
  parameter int PW    = 4,
  parameter int NCH   = 3,
  parameter int SEL_W = 2
);
  logic                  en;
  logic [PW-1:0]         param;
  logic [SEL_W-1:0]      select;
  logic                  ext;
  logic                  flush;
  logic [NCH*2*PW-1:0]   chan_data;
  logic [NCH-1:0]        chan_vld;
  logic                  pfx_pend;
  logic                  sel_err;

  modport master (
    output en, param, select, ext, flush,
    input  chan_data, chan_vld, pfx_pend, sel_err
  );

  modport slave (
    input  en, param, select, ext, flush,
    output chan_data, chan_vld, pfx_pend, sel_err
  );
endinterface

// File: rtl/prm_router.sv
// Registered PARAM-field router: steers a (optionally prefixed) parameter to one of NCH channels,
// with hold/clear of idle channels, per-channel valid pulses and an illegal-select error pulse.
module prm_router #(
  parameter int PW    = 4,
  parameter int NCH   = 3,
  parameter int SEL_W = 2,
  parameter int HOLD  = 0
) (
  input  logic         clk,
  input  logic         reset,
  prm_router_if.slave  bus
);
  localparam int DW = 2 * PW;

  typedef enum logic {
    IDLE,
    PFX
  } state_t;

  state_t              r_state;
  logic [PW-1:0]       r_hi;
  logic [NCH*DW-1:0]   r_data;
  logic [NCH-1:0]      r_vld;
  logic                r_err;

  state_t              w_state_nxt;
  logic [PW-1:0]       w_hi_nxt;
  logic [NCH*DW-1:0]   w_data_nxt;
  logic [NCH-1:0]      w_vld_nxt;
  logic                w_err_nxt;
  logic [DW-1:0]       w_value;

  assign w_value = (r_state == PFX) ? {r_hi, bus.param} : {{PW{1'b0}}, bus.param};

  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi;
    w_data_nxt  = r_data;
    w_vld_nxt   = '0;
    w_err_nxt   = 1'b0;
    if (bus.flush) begin
      w_state_nxt = IDLE;
      w_hi_nxt    = '0;
    end else if (bus.en) begin
      if (bus.ext) begin
        w_state_nxt = PFX;
        w_hi_nxt    = bus.param;
      end else begin
        // Any final-part strobe consumes the prefix, whether or not it delivers.
        w_state_nxt = IDLE;
        w_hi_nxt    = '0;
        if (HOLD == 0)
          w_data_nxt = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
          if (int'(bus.select) == int'(k) + 1) begin
            w_data_nxt[k*DW +: DW] = w_value;
            w_vld_nxt[k]           = 1'b1;
          end
        end
        if (int'(bus.select) > NCH)
          w_err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_hi    <= '0;
      r_data  <= '0;
      r_vld   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hi    <= w_hi_nxt;
      r_data  <= w_data_nxt;
      r_vld   <= w_vld_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.chan_data = r_data;
  assign bus.chan_vld  = r_vld;
  assign bus.pfx_pend  = (r_state == PFX);
  assign bus.sel_err   = r_err;
endmodule

// File: tb/tb_prm_router.sv
// Bench for prm_router: three configurations driven in lockstep and checked against a behavioural model.
module tb_prm_router;
  logic       clk = 1'b0;
  logic       reset;
  logic       t_en, t_ext, t_flush;
  logic [1:0] t_sel;
  logic [3:0] t_param;
  int         checks = 0;
  int         errors = 0;

  prm_router_if #(.PW(4), .NCH(3), .SEL_W(2)) if0 ();
  prm_router_if #(.PW(4), .NCH(3), .SEL_W(2)) if1 ();
  prm_router_if #(.PW(4), .NCH(2), .SEL_W(2)) if2 ();

  assign if0.en = t_en;  assign if0.ext = t_ext;  assign if0.flush = t_flush;
  assign if0.select = t_sel;  assign if0.param = t_param;
  assign if1.en = t_en;  assign if1.ext = t_ext;  assign if1.flush = t_flush;
  assign if1.select = t_sel;  assign if1.param = t_param;
  assign if2.en = t_en;  assign if2.ext = t_ext;  assign if2.flush = t_flush;
  assign if2.select = t_sel;  assign if2.param = t_param;

  prm_router #(.PW(4), .NCH(3), .SEL_W(2), .HOLD(0)) u_h0 (.clk(clk), .reset(reset), .bus(if0));
  prm_router #(.PW(4), .NCH(3), .SEL_W(2), .HOLD(1)) u_h1 (.clk(clk), .reset(reset), .bus(if1));
  prm_router #(.PW(4), .NCH(2), .SEL_W(2), .HOLD(0)) u_n2 (.clk(clk), .reset(reset), .bus(if2));

  always #5 clk = ~clk;

  // Reference model state, one entry per configuration.
  int         m_nch[3]  = '{3, 3, 2};
  int         m_hold[3] = '{0, 1, 0};
  logic [7:0] m_ch[3][3];
  logic       m_pend[3];
  logic [3:0] m_hi[3];
  logic [2:0] m_vld[3];
  logic       m_err[3];

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 3; c++) m_ch[d][c] = 8'h00;
      m_pend[d] = 1'b0; m_hi[d] = 4'h0; m_vld[d] = 3'b000; m_err[d] = 1'b0;
    end
  endtask

  task automatic model_step();
    int s;
    logic [7:0] val;
    s = int'(t_sel);
    for (int d = 0; d < 3; d++) begin
      m_vld[d] = 3'b000;
      m_err[d] = 1'b0;
      if (t_flush) begin
        m_pend[d] = 1'b0; m_hi[d] = 4'h0;
      end else if (t_en && t_ext) begin
        m_pend[d] = 1'b1; m_hi[d] = t_param;
      end else if (t_en) begin
        val = m_pend[d] ? (8'(m_hi[d]) * 8'd16 + 8'(t_param)) : 8'(t_param);
        if (m_hold[d] == 0)
          for (int c = 0; c < 3; c++) m_ch[d][c] = 8'h00;
        if (s >= 1 && s <= m_nch[d]) begin
          m_ch[d][s-1] = val;
          m_vld[d] = 3'(1 << (s - 1));
        end else if (s > m_nch[d]) begin
          m_err[d] = 1'b1;
        end
        m_pend[d] = 1'b0; m_hi[d] = 4'h0;
      end
    end
  endtask

  function automatic logic [23:0] obs_data(int d);
    case (d)
      0:       return if0.chan_data;
      1:       return if1.chan_data;
      default: return {8'h00, if2.chan_data};
    endcase
  endfunction

  function automatic logic [2:0] obs_vld(int d);
    case (d)
      0:       return if0.chan_vld;
      1:       return if1.chan_vld;
      default: return {1'b0, if2.chan_vld};
    endcase
  endfunction

  function automatic logic [1:0] obs_flags(int d);
    case (d)
      0:       return {if0.pfx_pend, if0.sel_err};
      1:       return {if1.pfx_pend, if1.sel_err};
      default: return {if2.pfx_pend, if2.sel_err};
    endcase
  endfunction

  task automatic chk(string tag, int d, logic [23:0] obs, logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_data"}, d, obs_data(d), {m_ch[d][2], m_ch[d][1], m_ch[d][0]});
      chk({tag, "_vld"},  d, 24'(obs_vld(d)), 24'(m_vld[d]));
      chk({tag, "_pend"}, d, 24'(obs_flags(d) >> 1), 24'(m_pend[d]));
      chk({tag, "_err"},  d, 24'(obs_flags(d) & 2'b01), 24'(m_err[d]));
    end
  endtask

  task automatic step(string tag, logic en, logic ext, logic [1:0] sel, logic [3:0] prm, logic fl);
    t_en = en; t_ext = ext; t_sel = sel; t_param = prm; t_flush = fl;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    t_en = 1'b0; t_ext = 1'b0; t_sel = 2'd0; t_param = 4'h0; t_flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    step("t1",      1'b1, 1'b0, 2'd1, 4'hA, 1'b0);
    step("t2_pfx",  1'b1, 1'b1, 2'd0, 4'h3, 1'b0);
    step("t2_low",  1'b1, 1'b0, 2'd2, 4'hC, 1'b0);
    step("t3_ld",   1'b1, 1'b0, 2'd1, 4'h5, 1'b0);
    step("t3_sel3", 1'b1, 1'b0, 2'd3, 4'h7, 1'b0);
    step("t4_pfx",  1'b1, 1'b1, 2'd0, 4'h6, 1'b0);
    step("t4_ill",  1'b1, 1'b0, 2'd3, 4'h1, 1'b0);
    step("t4_after",1'b1, 1'b0, 2'd1, 4'h4, 1'b0);
    step("pfx_ovw1",1'b1, 1'b1, 2'd2, 4'h1, 1'b0);
    step("pfx_ovw2",1'b1, 1'b1, 2'd1, 4'h8, 1'b0);
    step("idle_en0",1'b0, 1'b0, 2'd1, 4'h3, 1'b0);
    step("sel0",    1'b1, 1'b0, 2'd0, 4'hB, 1'b0);
    step("t5_pfx",  1'b1, 1'b1, 2'd0, 4'hF, 1'b0);
    step("t5_flush",1'b1, 1'b0, 2'd1, 4'h2, 1'b1);
    step("t5_next", 1'b1, 1'b0, 2'd1, 4'h2, 1'b0);
    step("t6_pfx",  1'b1, 1'b1, 2'd0, 4'h5, 1'b0);

    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("t6_async");
    @(posedge clk);
    #1;
    check_all("t6_held");
    reset = 1'b0;
    step("t6_after",1'b1, 1'b0, 2'd1, 4'h9, 1'b0);

    repeat (400) begin
      step("rand",
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 3,
           2'($urandom_range(0, 3)),
           4'($urandom),
           $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
